// File: rtl/sram_rw_initiator.sv
// Request-side driver for a single-port masked RW SRAM macro: optional zero-fill after reset,
// valid/ready request stream to RW0 port cycles, read data returned through a 2-entry skid buffer.
module sram_rw_initiator #(
    parameter int unsigned ADDR_W        = 9,
    parameter int unsigned DATA_W        = 256,
    parameter int unsigned MASK_W        = 32,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_wmask,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,

    output logic              init_done,

    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [MASK_W-1:0] RW0_wmask,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);

    typedef enum logic [1:0] {StBoot, StInit, StRun} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              init_done_q, init_done_d;

    logic              inflight_q, inflight_d;
    logic [1:0]        occ_q, occ_d;
    logic              rd_ptr_q, wr_ptr_q;
    logic [DATA_W-1:0] buf_q [2];

    logic              run;
    logic [1:0]        credits;
    logic              accept;
    logic              push;
    logic              pop;

    // ------------------------------------------------------------------
    // Boot / zero-fill / run sequencing
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        case (state_q)
            StBoot: begin
                cnt_d = '0;
                if (INIT_ON_RESET) begin
                    state_d = StInit;
                end else begin
                    state_d     = StRun;
                    init_done_d = 1'b1;
                end
            end
            StInit: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastAddr) begin
                    state_d     = StRun;
                    init_done_d = 1'b1;
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StBoot;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    assign init_done = init_done_q;
    assign run       = (state_q == StRun);

    // A read in flight and each buffered word both hold one of the two response credits.
    assign credits   = 2'(inflight_q) + occ_q;
    assign req_ready = run && (credits < 2'd2);
    assign accept    = req_valid && req_ready;

    // ------------------------------------------------------------------
    // SRAM port drive
    // ------------------------------------------------------------------
    always_comb begin
        RW0_en    = 1'b0;
        RW0_wmode = 1'b0;
        RW0_addr  = '0;
        RW0_wmask = '0;
        RW0_wdata = '0;
        case (state_q)
            StInit: begin
                RW0_en    = 1'b1;
                RW0_wmode = 1'b1;
                RW0_addr  = cnt_q;
                RW0_wmask = '1;
            end
            StRun: begin
                RW0_en    = accept;
                RW0_wmode = accept && req_write;
                RW0_addr  = req_addr;
                RW0_wmask = req_wmask;
                RW0_wdata = req_wdata;
            end
            default: begin
                RW0_en = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Response path: flow-through when the buffer is empty, skid buffer otherwise
    // ------------------------------------------------------------------
    assign resp_valid = (occ_q != 2'd0) || inflight_q;

    always_comb begin
        if (occ_q != 2'd0) begin
            resp_rdata = buf_q[rd_ptr_q];
        end else if (inflight_q) begin
            resp_rdata = RW0_rdata;
        end else begin
            resp_rdata = '0;
        end
    end

    assign push       = inflight_q && !((occ_q == 2'd0) && resp_ready);
    assign pop        = resp_valid && resp_ready && (occ_q != 2'd0);
    assign occ_d      = occ_q + 2'(push) - 2'(pop);
    assign inflight_d = accept && !req_write;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            if (push) begin
                buf_q[wr_ptr_q] <= RW0_rdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // The credit check on req_ready must make a third buffered word unreachable.
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && (occ_q == 2'd2)));
    a_occ_bound: assert property (@(posedge clock) disable iff (reset) occ_q <= 2'd2);

endmodule

// File: tb/tb_sram_rw_initiator.sv
// Bench for sram_rw_initiator: behavioural macro, reference memory and response queue model,
// per-cycle output comparison plus directed literal checks; a second instance covers no-init.
module tb_sram_rw_initiator;
    localparam int AW    = 9;
    localparam int DW    = 256;
    localparam int MW    = 32;
    localparam int DEPTH = 512;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic          req_valid, req_ready, req_write, resp_valid, resp_ready, init_done;
    logic [AW-1:0] req_addr, RW0_addr;
    logic [DW-1:0] req_wdata, resp_rdata, RW0_wdata, RW0_rdata;
    logic [MW-1:0] req_wmask, RW0_wmask;
    logic          RW0_en, RW0_wmode;

    logic          req2_valid, req2_ready, req2_write, resp2_valid, resp2_ready, init2_done;
    logic [AW-1:0] req2_addr, RW0_addr2;
    logic [DW-1:0] req2_wdata, resp2_rdata, RW0_wdata2, RW0_rdata2;
    logic [MW-1:0] req2_wmask, RW0_wmask2;
    logic          RW0_en2, RW0_wmode2;

    sram_rw_initiator #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .INIT_ON_RESET(1'b1)) u_dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .init_done(init_done),
        .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
        .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
    );

    sram_rw_initiator #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .INIT_ON_RESET(1'b0)) u_dut2 (
        .clock(clock), .reset(reset),
        .req_valid(req2_valid), .req_ready(req2_ready), .req_write(req2_write),
        .req_addr(req2_addr), .req_wdata(req2_wdata), .req_wmask(req2_wmask),
        .resp_valid(resp2_valid), .resp_ready(resp2_ready), .resp_rdata(resp2_rdata),
        .init_done(init2_done),
        .RW0_addr(RW0_addr2), .RW0_en(RW0_en2), .RW0_wmode(RW0_wmode2),
        .RW0_wmask(RW0_wmask2), .RW0_wdata(RW0_wdata2), .RW0_rdata(RW0_rdata2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 100) $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] data,
                                            input logic [MW-1:0] mask);
        logic [DW-1:0] r;
        r = old;
        for (int g = 0; g < MW; g++) if (mask[g]) r[g*8 +: 8] = data[g*8 +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd256();
        logic [DW-1:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Behavioural macro: masked write, registered read, preloaded with random contents.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;
    assign RW0_rdata  = rdata_q;
    assign RW0_rdata2 = '0;
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = rnd256();
        rdata_q <= '0;
        forever begin
            @(posedge clock);
            if (RW0_en === 1'b1) begin
                if (RW0_wmode) mem[RW0_addr] = merge(mem[RW0_addr], RW0_wdata, RW0_wmask);
                else rdata_q <= mem[RW0_addr];
            end
        end
    end

    // Reference model: m_cyc counts clock edges since reset release.
    // 0 = boot cycle, 1..DEPTH = zero-fill of address m_cyc-1, beyond = normal traffic.
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            m_cyc = 0;
    int            m_out = 0;
    bit            m_acc = 1'b0;
    bit            m_rdy;
    initial begin
        #1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
        forever begin
            @(posedge clock or posedge reset);
            m_acc = 1'b0;
            if (reset) begin
                m_cyc = 0;
                m_out = 0;
                exp_q.delete();
            end else begin
                if (m_cyc >= 1 && m_cyc <= DEPTH) begin
                    ref_mem[m_cyc-1] = '0;
                end else if (m_cyc > DEPTH) begin
                    m_rdy = (m_out < 2);
                    if (m_out > 0 && resp_ready) begin
                        void'(exp_q.pop_front());
                        m_out--;
                    end
                    if (req_valid && m_rdy) begin
                        m_acc = 1'b1;
                        if (req_write) begin
                            ref_mem[req_addr] = merge(ref_mem[req_addr], req_wdata, req_wmask);
                        end else begin
                            exp_q.push_back(ref_mem[req_addr]);
                            m_out++;
                        end
                    end
                end
                m_cyc++;
            end
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    logic [DW-1:0] resp_log [$];
    int            init_seq = 0;
    int            rise_cyc = 0;
    bit            e_rdy, e_en;
    initial forever begin
        @(negedge clock);
        if (reset || m_cyc == 0) begin
            check("idle_req_ready", req_ready, 0);
            check("idle_resp_valid", resp_valid, 0);
            check("idle_init_done", init_done, 0);
            check("idle_en", RW0_en, 0);
            check("idle_wmode", RW0_wmode, 0);
            check("idle_addr", RW0_addr, 0);
            check("idle_wmask", RW0_wmask, 0);
            check("idle_wdata", RW0_wdata, 0);
            check("idle_rdata", resp_rdata, 0);
        end else if (m_cyc <= DEPTH) begin
            check("init_req_ready", req_ready, 0);
            check("init_resp_valid", resp_valid, 0);
            check("init_done_low", init_done, 0);
            check("init_en", RW0_en, 1);
            check("init_wmode", RW0_wmode, 1);
            check("init_addr", RW0_addr, m_cyc - 1);
            check("init_wmask", RW0_wmask, {MW{1'b1}});
            check("init_wdata", RW0_wdata, 0);
        end else begin
            e_rdy = (m_out < 2);
            e_en  = req_valid && e_rdy;
            check("run_init_done", init_done, 1);
            check("run_req_ready", req_ready, e_rdy);
            check("run_resp_valid", resp_valid, m_out > 0);
            check("run_en", RW0_en, e_en);
            check("run_wmode", RW0_wmode, e_en && req_write);
            if (e_en) begin
                check("run_addr", RW0_addr, req_addr);
                check("run_wmask", RW0_wmask, req_wmask);
                check("run_wdata", RW0_wdata, req_wdata);
            end
            if (m_out > 0) begin
                check("run_rdata", resp_rdata, exp_q[0]);
                if (resp_ready) resp_log.push_back(resp_rdata);
            end
        end
        if (reset) begin
            init_seq = 0;
            rise_cyc = 0;
        end else begin
            if (init_seq < DEPTH && RW0_en === 1'b1 && RW0_wmode === 1'b1 &&
                RW0_wmask === {MW{1'b1}} && RW0_wdata === '0 && RW0_addr === AW'(init_seq))
                init_seq++;
            if (rise_cyc == 0 && init_done === 1'b1) rise_cyc = m_cyc + 1;
        end
    end

    bit rand_rr = 1'b0;

    // All stimulus runs at 1 time unit after a rising edge.
    task automatic op(input logic wr, input int addr, input logic [DW-1:0] d,
                      input logic [MW-1:0] m);
        int n;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = AW'(addr);
        req_wdata = d;
        req_wmask = m;
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
            if (rand_rr) resp_ready = 1'($urandom_range(0, 1));
        end while (!m_acc && n < 50);
        if (!m_acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_timeout: got not accepted expected accepted");
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        resp_ready = 1'b1;
        n = 0;
        while (m_out > 0 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (m_cyc < DEPTH + 1 && n < 1000) begin
            @(posedge clock);
            #1;
            n++;
        end
        @(posedge clock);
        #1;
        check("init_write_count", init_seq, DEPTH);
        check("init_done_cycle", rise_cyc, DEPTH + 2);
    endtask

    logic [DW-1:0] pat_a5, pat_ff0, ones;
    int            base, cnt;

    initial begin
        req_valid  = 1'b0; req_write  = 1'b0; req_addr  = '0; req_wdata  = '0; req_wmask  = '0;
        req2_valid = 1'b0; req2_write = 1'b0; req2_addr = '0; req2_wdata = '0; req2_wmask = '0;
        resp_ready  = 1'b1;
        resp2_ready = 1'b1;
        pat_a5  = {32{8'hA5}};
        pat_ff0 = {{31{8'hA5}}, 8'hFF};
        ones    = '1;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // No-init instance: boot cycle, then usable immediately, no writes until asked.
        check("noinit_boot_ready", req2_ready, 0);
        check("noinit_boot_done", init2_done, 0);
        check("noinit_boot_en", RW0_en2, 0);
        @(posedge clock);
        #1;
        check("noinit_done_cycle2", init2_done, 1);
        check("noinit_ready_cycle2", req2_ready, 1);
        cnt = 0;
        repeat (20) begin
            if (RW0_en2 === 1'b1) cnt++;
            @(posedge clock);
            #1;
        end
        check("noinit_no_writes", cnt, 0);
        req2_valid = 1'b1; req2_write = 1'b1; req2_addr = 9'd7;
        req2_wdata = pat_a5; req2_wmask = '1;
        #1;
        check("noinit_write_en", RW0_en2, 1);
        check("noinit_write_wmode", RW0_wmode2, 1);
        check("noinit_write_addr", RW0_addr2, 7);
        @(posedge clock);
        #1;
        req2_valid = 1'b0;

        wait_init();

        // Zero-filled array reads back zero, in the cycle after acceptance.
        op(0, 37, '0, '0);
        check("rd37_valid_next", resp_valid, 1);
        check("rd37_data", resp_rdata, 0);

        // Read-after-write and partial-mask write.
        op(1, 5, pat_a5, '1);
        op(0, 5, '0, '0);
        check("raw_valid_next", resp_valid, 1);
        check("raw_data", resp_rdata, pat_a5);
        op(1, 5, ones, 32'h1);
        op(0, 5, '0, '0);
        check("mask_data", resp_rdata, pat_ff0);
        drain();

        // Credit limit with a stalled consumer.
        op(1, 1, 256'd1, '1);
        op(1, 2, 256'd2, '1);
        op(1, 3, 256'd3, '1);
        base = resp_log.size();
        resp_ready = 1'b0;
        op(0, 1, '0, '0);
        op(0, 2, '0, '0);
        check("credit_block_c3", req_ready, 0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 9'd3;
        @(posedge clock);
        #1;
        check("credit_block_c4", req_ready, 0);
        check("stalled_valid", resp_valid, 1);
        resp_ready = 1'b1;
        op(0, 3, '0, '0);
        drain();
        check("order_first", resp_log[base], 256'd1);
        check("order_second", resp_log[base+1], 256'd2);
        check("order_third", resp_log[base+2], 256'd3);

        // Random traffic with a randomly stalling consumer.
        rand_rr = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock);
                #1;
                resp_ready = 1'b0;
            end
            op(1'($urandom_range(0, 1)), $urandom_range(0, 15), rnd256(), MW'($urandom));
        end
        rand_rr = 1'b0;
        drain();

        // Reset in the middle of zero-fill: restart from address 0.
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        cnt = 0;
        while (m_cyc < 101 && cnt < 200) begin
            @(posedge clock);
            #1;
            cnt++;
        end
        check("midinit_addr100", RW0_addr, 100);
        reset = 1'b1;
        #1;
        check("midinit_rst_en", RW0_en, 0);
        check("midinit_rst_addr", RW0_addr, 0);
        repeat (3) @(posedge clock);
        #1;
        check("midinit_rst_done", init_done, 0);
        check("midinit_rst_ready", req_ready, 0);
        reset = 1'b0;
        wait_init();
        op(0, 37, '0, '0);
        check("reinit_rd37", resp_rdata, 0);
        op(0, 5, '0, '0);
        check("reinit_rd5", resp_rdata, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_rw_initiator.md
Name: sram_rw_initiator

Overview:
- Request-side driver for a single-port masked read/write SRAM macro (RW0_* port: addr/en/wmode/wmask/wdata in, rdata out, 1-cycle registered read).
- Converts a valid/ready request stream into SRAM port cycles and returns read data on a valid/ready response stream through a 2-entry skid buffer.
- Optionally zero-fills the whole array after reset before accepting traffic.
- Sits between cache/scratchpad control logic and the *_ext SRAM macros. The parent module ties the macro's RW0_clk to clock.

Parameters:
- ADDR_W, 9, SRAM address width; depth = 2^ADDR_W.
- DATA_W, 256, SRAM word width.
- MASK_W, 32, write-mask bits; granule = DATA_W/MASK_W, which must divide exactly.
- INIT_ON_RESET, 1, when 1, zero-fill all addresses after reset.

Ports:
- clock, in, 1, sole clock.
- reset, in, 1, asynchronous, active-high.
- req_valid, in, 1, request present.
- req_ready, out, 1, request accepted when valid&ready.
- req_write, in, 1, 1=write, 0=read.
- req_addr, in, ADDR_W, word address.
- req_wdata, in, DATA_W, write data.
- req_wmask, in, MASK_W, per-granule write enable.
- resp_valid, out, 1, read data available.
- resp_ready, in, 1, consumer accepts read data.
- resp_rdata, out, DATA_W, read data.
- init_done, out, 1, high once array is usable; stays high until next reset.
- RW0_addr, out, ADDR_W, to macro.
- RW0_en, out, 1, to macro.
- RW0_wmode, out, 1, to macro; 1=write.
- RW0_wmask, out, MASK_W, to macro.
- RW0_wdata, out, DATA_W, to macro.
- RW0_rdata, in, DATA_W, from macro; valid the cycle after a read enable.

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset). All state is cleared asynchronously.
- While reset is asserted, and in the first cycle after release, all outputs are 0: req_ready, resp_valid, init_done, RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata, resp_rdata.
- FSM states: BOOT, INIT, RUN. Reset value is BOOT.
  - BOOT lasts exactly 1 cycle, then goes to INIT if INIT_ON_RESET=1, else to RUN.
- INIT:
  - Counter starts at 0. Each cycle: RW0_en=1, RW0_wmode=1, RW0_wmask=all ones, RW0_wdata=0, RW0_addr=counter; counter increments.
  - After the write to address 2^ADDR_W-1, go to RUN.
  - req_ready=0 throughout INIT. INIT lasts exactly 2^ADDR_W cycles.
- RUN:
  - init_done=1, registered: asserts in the first RUN cycle.
  - req_ready = (inflight + occ) < 2, where inflight is a 1-bit "read issued last cycle" flag and occ (0..2) is skid-buffer occupancy.
  - The SRAM port is driven combinationally from the request:
    - RW0_en = req_valid & req_ready.
    - RW0_wmode = req_write.
    - RW0_addr = req_addr, RW0_wmask = req_wmask, RW0_wdata = req_wdata.
  - When RW0_en=0, the address, mask and data outputs are don't-care; RW0_wmode=0.
  - Writes generate no response. Exactly one SRAM operation per cycle.
- Read response path:
  - A read accepted in cycle T sets inflight for T+1. Its data is on RW0_rdata in T+1.
  - resp_valid = (occ>0) | inflight.
  - resp_rdata = buffer head if occ>0, else RW0_rdata (flow-through). Minimum read latency is 1 cycle.
  - In a cycle with inflight=1, RW0_rdata is pushed into the buffer unless (occ=0 & resp_ready=1).
  - Pop when resp_valid & resp_ready & occ>0. Push and pop may occur in the same cycle.
  - Responses return strictly in request order.
  - Credit rule guarantees occ never exceeds 2. Overflow is impossible and is asserted in simulation.
- Throughput:
  - With resp_ready held at 1, reads and writes are accepted every cycle.
  - With resp_ready held at 0, at most 2 reads are outstanding (buffered plus inflight); req_ready then drops.
  - req_ready also gates writes while credits are exhausted, so requests are never reordered.
- Read-after-write to the same address in consecutive cycles returns the new data (macro semantics). Masked-off granules are preserved.
- Reset mid-operation (INIT or RUN): restart at BOOT. Pending responses are discarded, init_done drops to 0, and the counter clears.
- req_* inputs are ignored when req_ready=0. resp_rdata is don't-care when resp_valid=0.

Test Plan:
- INIT_ON_RESET=1, ADDR_W=9, with a behavioural macro pre-loaded with random data: release reset.
  - Required: exactly 512 consecutive write cycles to addresses 0..511 with all-ones mask and zero data.
  - Required: init_done rises on cycle 514 after reset release.
  - Then read address 37, required to return 0.
- Write 0xA5 repeated to address 5 with full mask; next cycle read address 5.
  - Required: resp_valid in the cycle after acceptance with rdata = 0xA5 pattern.
  - Then write 0xFF.. with wmask = 0x1 and read back: only byte 0 changes.
- resp_ready=0; issue reads to addresses 1, 2, 3.
  - Required: only 2 are accepted, and req_ready=0 in the third cycle.
  - Raise resp_ready: data for addresses 1 then 2 is returned, then the read of 3 is accepted and returned.
- resp_ready toggled randomly during 200 random reads/writes.
  - Required: responses in order, matching a scoreboard, and occ never exceeds 2.
- Assert reset at INIT counter=100, release, and observe.
  - Required: all outputs 0 during reset; INIT restarts at address 0 and completes the full 512 cycles.
- INIT_ON_RESET=0: release reset.
  - Required: init_done=1 and req_ready=1 in the second cycle after release.
  - Required: no SRAM writes are issued before the first request.
